// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: sweeps a binary code range (lo..hi, up or down, modulo
// 2^WIDTH), holds each code for HOLD cycles and presents the binary code with
// its Gray equivalent. Drives and self-checks the binary-to-Gray datapath.
// Optional macro GRAY_CHECK_EN adds a sticky single-bit-step checker on err;
// without it err is tied low.
module gray_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             abort,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   code_cnt,
  output logic             err
);

  // Hold counter needs at least one bit even when HOLD is 1.
  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_STEP,
    ST_DONE
  } state_t;

  state_t             r_state, w_nextState;
  logic [HW-1:0]      r_holdCnt, w_nextHoldCnt;
  logic               r_up, w_nextUp;
  logic [WIDTH-1:0]   r_end, w_nextEnd;
  logic [WIDTH-1:0]   r_bin, w_nextBin;
  logic [WIDTH-1:0]   r_gray, w_nextGray;
  logic               r_valid, w_nextValid;
  logic               r_done, w_nextDone;
  logic [WIDTH:0]     r_cnt, w_nextCnt;

  logic [WIDTH-1:0]   w_startCode;
  logic [WIDTH-1:0]   w_stepBin;
  logic [WIDTH-1:0]   w_stepGray;

  function automatic logic [WIDTH-1:0] toGray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // The first code of a sweep depends on direction; the next code wraps
  // naturally through the WIDTH-bit adder.
  assign w_startCode = up ? lo : hi;
  assign w_stepBin   = r_up ? (r_bin + 1'b1) : (r_bin - 1'b1);
  assign w_stepGray  = toGray(w_stepBin);

  // Next-state and next-output decode for the sweep sequencer
  always_comb begin
    w_nextState   = r_state;
    w_nextHoldCnt = r_holdCnt;
    w_nextUp      = r_up;
    w_nextEnd     = r_end;
    w_nextBin     = r_bin;
    w_nextGray    = r_gray;
    w_nextValid   = 1'b0;
    w_nextDone    = 1'b0;
    w_nextCnt     = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextUp      = up;
          w_nextEnd     = up ? hi : lo;
          w_nextBin     = w_startCode;
          w_nextGray    = toGray(w_startCode);
          w_nextValid   = 1'b1;
          w_nextCnt     = (WIDTH+1)'(1);
          w_nextHoldCnt = '0;
          w_nextState   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          w_nextState = ST_IDLE;
        end else if (r_holdCnt == HOLD_LAST) begin
          w_nextHoldCnt = '0;
          if (r_bin == r_end) begin
            w_nextDone  = 1'b1;
            w_nextState = ST_DONE;
          end else begin
            w_nextState = ST_STEP;
          end
        end else begin
          w_nextHoldCnt = r_holdCnt + 1'b1;
        end
      end
      ST_STEP: begin
        if (abort) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextBin   = w_stepBin;
          w_nextGray  = w_stepGray;
          w_nextValid = 1'b1;
          w_nextCnt   = r_cnt + 1'b1;
          w_nextState = ST_HOLD;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_holdCnt <= '0;
      r_up      <= 1'b0;
      r_end     <= '0;
      r_bin     <= '0;
      r_gray    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_holdCnt <= w_nextHoldCnt;
      r_up      <= w_nextUp;
      r_end     <= w_nextEnd;
      r_bin     <= w_nextBin;
      r_gray    <= w_nextGray;
      r_valid   <= w_nextValid;
      r_done    <= w_nextDone;
      r_cnt     <= w_nextCnt;
    end
  end

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] w_grayDelta;
  logic             w_grayBad;
  logic             r_err;

  // A legal Gray step changes exactly one bit: delta non-zero and a power of two.
  assign w_grayDelta = w_stepGray ^ r_gray;
  assign w_grayBad   = (w_grayDelta == '0) ||
                       ((w_grayDelta & (w_grayDelta - 1'b1)) != '0);

  // Sticky adjacency flag: cleared by an accepted start, set by a bad step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_STEP) && !abort && w_grayBad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign valid    = r_valid;
  assign done     = r_done;
  assign code_cnt = r_cnt;
  assign busy     = (r_state == ST_HOLD) || (r_state == ST_STEP);

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Testbench for gray_sweep_ctrl: directed and randomized sweeps checked
// cycle by cycle against an arithmetic timeline model of the sequencer.
module tb_gray_sweep_ctrl;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int NCODES = 1 << W;
  localparam int PERIOD = H + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         up;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         abort;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         valid;
  logic         busy;
  logic         done;
  logic [W:0]   code_cnt;
  logic         err;

  int testCount = 0;
  int failCount = 0;

  gray_sweep_ctrl #(.WIDTH(W), .HOLD(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .up       (up),
    .lo       (lo),
    .hi       (hi),
    .abort    (abort),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .code_cnt (code_cnt),
    .err      (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: codes in a sweep, the k-th code, and its Gray value.
  function automatic int codeCount(input int l, input int h);
    return (((h - l) % NCODES) + NCODES) % NCODES + 1;
  endfunction

  function automatic int codeAt(input bit u, input int l, input int h, input int k);
    if (u) return (l + k) % NCODES;
    return (((h - k) % NCODES) + NCODES) % NCODES;
  endfunction

  function automatic int grayOf(input int b);
    return b ^ (b >> 1);
  endfunction

  // Run one sweep and check every cycle. abortAt/spurAt/rstAt give the cycle
  // (counted from the first valid cycle = 1) at which that input is raised;
  // -1 means never.
  task automatic applyStimulus(input string name, input bit u, input int l, input int h,
                               input int abortAt, input int spurAt, input int rstAt);
    int  n;
    int  doneT;
    int  lastT;
    int  k;
    int  expBin, expCnt;
    bit  expValid, expBusy, expDone;
    bit  halted;
    bit  wasReset;
    int  frozenBin, frozenCnt;

    n        = codeCount(l, h);
    doneT    = n * PERIOD;
    lastT    = doneT + 2;
    halted   = 1'b0;
    wasReset = 1'b0;
    frozenBin = 0;
    frozenCnt = 0;

    @(negedge clk);
    start = 1'b1;
    up    = u;
    lo    = W'(l);
    hi    = W'(h);

    for (int t = 1; t <= lastT; t++) begin
      @(negedge clk);
      if (wasReset) begin
        expBin = 0; expCnt = 0; expValid = 0; expBusy = 0; expDone = 0;
      end else if (halted) begin
        expBin = frozenBin; expCnt = frozenCnt; expValid = 0; expBusy = 0; expDone = 0;
      end else if (t < doneT) begin
        k        = (t - 1) / PERIOD;
        expBin   = codeAt(u, l, h, k);
        expCnt   = k + 1;
        expValid = ((t - 1) % PERIOD) == 0;
        expBusy  = 1'b1;
        expDone  = 1'b0;
      end else begin
        expBin   = codeAt(u, l, h, n - 1);
        expCnt   = n;
        expValid = 1'b0;
        expBusy  = 1'b0;
        expDone  = (t == doneT);
      end

      checkOutput($sformatf("%s t=%0d bin", name, t), 32'(bin_out), 32'(expBin));
      checkOutput($sformatf("%s t=%0d gray", name, t), 32'(gray_out),
                  32'(wasReset ? 0 : grayOf(expBin)));
      checkOutput($sformatf("%s t=%0d valid", name, t), 32'(valid), 32'(expValid));
      checkOutput($sformatf("%s t=%0d busy", name, t), 32'(busy), 32'(expBusy));
      checkOutput($sformatf("%s t=%0d done", name, t), 32'(done), 32'(expDone));
      checkOutput($sformatf("%s t=%0d cnt", name, t), 32'(code_cnt), 32'(expCnt));
      checkOutput($sformatf("%s t=%0d err", name, t), 32'(err), 32'd0);

      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (t == spurAt) begin
        start = 1'b1;
        up    = ~u;
        lo    = W'($urandom);
        hi    = W'($urandom);
      end
      if (t == abortAt) begin
        abort = 1'b1;
        if (t < doneT && !halted && !wasReset) begin
          halted    = 1'b1;
          frozenBin = codeAt(u, l, h, (t - 1) / PERIOD);
          frozenCnt = (t - 1) / PERIOD + 1;
        end
      end
      if (t == rstAt) begin
        rst      = 1'b1;
        wasReset = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

`ifdef GRAY_CHECK_EN
  // Corrupt one Gray step into a 2-bit jump and confirm err latches until
  // the next accepted start.
  task automatic checkGrayErr();
    @(negedge clk);
    start = 1'b1; up = 1'b1; lo = 4'd0; hi = 4'd3;
    for (int t = 1; t <= 4 * PERIOD; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == PERIOD) force dut.w_stepGray = 4'b0011;
      if (t == PERIOD + 1) begin
        release dut.w_stepGray;
        checkOutput("gchk err set", 32'(err), 32'd1);
      end
      if (t == 4 * PERIOD) begin
        checkOutput("gchk done", 32'(done), 32'd1);
        checkOutput("gchk err held", 32'(err), 32'd1);
      end
    end
    @(negedge clk);
    start = 1'b1; up = 1'b1; lo = 4'd5; hi = 4'd5;
    @(negedge clk);
    start = 1'b0;
    checkOutput("gchk err cleared", 32'(err), 32'd0);
    repeat (PERIOD + 2) @(negedge clk);
  endtask
`endif

  // Main stimulus sequence
  initial begin
    int  l, h, n, doneT, mode, aAt, sAt, rAt;
    bit  u;

    rst = 1'b1; start = 1'b0; abort = 1'b0; up = 1'b1; lo = '0; hi = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset bin", 32'(bin_out), 32'd0);
    checkOutput("reset gray", 32'(gray_out), 32'd0);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset cnt", 32'(code_cnt), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    applyStimulus("full-up", 1'b1, 0, 15, -1, -1, -1);
    applyStimulus("down", 1'b0, 3, 6, -1, -1, -1);
    applyStimulus("wrap-up", 1'b1, 14, 1, -1, -1, -1);
    applyStimulus("wrap-down", 1'b0, 14, 1, -1, -1, -1);
    applyStimulus("single", 1'b1, 5, 5, -1, -1, -1);
    applyStimulus("abort3", 1'b1, 0, 15, 2 * PERIOD + 1, 4, -1);
    applyStimulus("abort-done", 1'b0, 9, 11, 3 * PERIOD, -1, -1);
    applyStimulus("reset-mid", 1'b1, 0, 15, -1, -1, 10);
    applyStimulus("after-reset", 1'b1, 2, 9, -1, -1, -1);

`ifdef GRAY_CHECK_EN
    checkGrayErr();
`endif

    for (int i = 0; i < 150; i++) begin
      u     = 1'($urandom);
      l     = int'($urandom_range(0, NCODES - 1));
      h     = int'($urandom_range(0, NCODES - 1));
      n     = codeCount(l, h);
      doneT = n * PERIOD;
      mode  = int'($urandom_range(0, 3));
      aAt = -1; sAt = -1; rAt = -1;
      case (mode)
        1: aAt = int'($urandom_range(1, doneT));
        2: if (doneT > 1) rAt = int'($urandom_range(1, doneT - 1));
        3: if (doneT > 1) sAt = int'($urandom_range(1, doneT - 1));
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d", i), u, l, h, aAt, sAt, rAt);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
